// File: rtl/ft245_sync_tx_if.sv
// Fabric-side word port and FT2232H 245-synchronous FIFO pins for ft245_sync_tx.
// The slave modport is the transmit engine; the master modport is the fabric/device side.
interface ft245_sync_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);
  logic [DATA_WIDTH-1:0]    s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic                     txe_n;
  logic [7:0]               data;
  logic                     wr_n;
  logic                     rd_n;
  logic                     oe_n;
  logic                     siwu_n;
  logic [$clog2(DEPTH):0]   level;
  logic                     busy;

  modport slave (
    input  s_data, s_valid, txe_n,
    output s_ready, data, wr_n, rd_n, oe_n, siwu_n, level, busy
  );

  modport master (
    output s_data, s_valid, txe_n,
    input  s_ready, data, wr_n, rd_n, oe_n, siwu_n, level, busy
  );
endinterface

// File: rtl/ft245_sync_tx.sv
// FT2232H 245-synchronous transmit engine: word FIFO -> byte serialiser -> byte holding register,
// one byte per comm_clk while TXE# permits, plus a one-shot SIWU# flush after the link idles.
module ft245_sync_tx #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int MSB_FIRST     = 0,
  parameter int FLUSH_TIMEOUT = 64
) (
  input  logic                comm_clk,
  input  logic                rst,
  ft245_sync_tx_if.slave      bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(NB + 1);
  localparam int CW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [LW-1:0]         r_level;
  logic                  r_rst_done;
  logic [DATA_WIDTH-1:0] r_ser_word;
  logic [BW-1:0]         r_ser_cnt;
  logic [7:0]            r_data;
  logic                  r_wr_n;
  logic [CW-1:0]         r_idle_cnt;
  logic                  r_armed;
  logic                  r_siwu_n;

  logic                  w_s_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_xfer;
  logic                  w_hold_take;
  logic                  w_ser_give;
  logic                  w_ser_empty_next;
  logic                  w_idle;
  logic                  w_fire;
  logic [7:0]            w_ser_byte;
  logic [DATA_WIDTH-1:0] w_ser_shift;

  assign w_s_ready   = r_rst_done && (r_level < LW'(DEPTH));
  assign w_push      = bus.s_valid && w_s_ready;
  assign w_xfer      = !r_wr_n && !bus.txe_n;
  // Holding register accepts a new byte when empty or when its byte leaves this edge.
  assign w_hold_take = r_wr_n || w_xfer;
  assign w_ser_give  = w_hold_take && (r_ser_cnt != '0);
  assign w_ser_empty_next = (r_ser_cnt == '0) || (w_ser_give && (r_ser_cnt == BW'(1)));
  assign w_pop       = w_ser_empty_next && (r_level != '0);

  assign w_ser_byte  = (MSB_FIRST != 0) ? r_ser_word[DATA_WIDTH-1 -: 8] : r_ser_word[7:0];
  assign w_ser_shift = (MSB_FIRST != 0) ? (r_ser_word << 8) : (r_ser_word >> 8);

  assign w_idle = r_armed && r_wr_n && (r_ser_cnt == '0) && (r_level == '0);
  assign w_fire = (FLUSH_TIMEOUT != 0) && w_idle && !w_push &&
                  (r_idle_cnt == CW'(FLUSH_TIMEOUT - 1));

  always_ff @(posedge comm_clk) begin
    if (w_push) r_mem[r_wptr] <= bus.s_data;
  end

  always_ff @(posedge comm_clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  always_ff @(posedge comm_clk or posedge rst) begin
    if (rst) begin
      r_ser_word <= '0;
      r_ser_cnt  <= '0;
    end else if (w_pop) begin
      r_ser_word <= r_mem[r_rptr];
      r_ser_cnt  <= BW'(NB);
    end else if (w_ser_give) begin
      r_ser_word <= w_ser_shift;
      r_ser_cnt  <= r_ser_cnt - 1'b1;
    end
  end

  always_ff @(posedge comm_clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_wr_n <= 1'b1;
    end else if (w_hold_take) begin
      if (r_ser_cnt != '0) begin
        r_data <= w_ser_byte;
        r_wr_n <= 1'b0;
      end else begin
        r_wr_n <= 1'b1;
      end
    end
  end

  // Idle counter saturates at FLUSH_TIMEOUT; the cycle after the pulse disarms until the next transfer.
  always_ff @(posedge comm_clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= '0;
      r_armed    <= 1'b0;
      r_siwu_n   <= 1'b1;
    end else begin
      r_siwu_n <= !w_fire;
      if (w_xfer) begin
        r_armed    <= 1'b1;
        r_idle_cnt <= '0;
      end else if (w_push) begin
        r_idle_cnt <= '0;
      end else if ((FLUSH_TIMEOUT != 0) && (r_idle_cnt == CW'(FLUSH_TIMEOUT))) begin
        r_idle_cnt <= '0;
        r_armed    <= 1'b0;
      end else if (w_idle && (r_idle_cnt < CW'(FLUSH_TIMEOUT))) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.data    = r_data;
  assign bus.wr_n    = r_wr_n;
  assign bus.rd_n    = 1'b1;
  assign bus.oe_n    = 1'b1;
  assign bus.siwu_n  = r_siwu_n;
  assign bus.level   = r_level;
  assign bus.busy    = (r_level != '0) || (r_ser_cnt != '0) || !r_wr_n;
endmodule
